// File: rtl/flash_audio_pkg.sv
// Shared types for the flash audio streamer.
// FSM state encoding and sample-index sizing helper.
package flash_audio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_PLAY = 3'd3,
        ST_ADV  = 3'd4
    } state_e;

    function automatic int samples_per_word(input int data_w, input int sample_w);
        return data_w / sample_w;
    endfunction

    function automatic int idx_width(input int samples);
        return (samples > 1) ? $clog2(samples) : 1;
    endfunction

endpackage

// File: rtl/flash_addr_ctr.sv
// Up/down word-address counter confined to [ADDR_MIN, ADDR_MAX].
// Steps wrap at either end; loads jump to either edge of the window.
module flash_addr_ctr #(
    parameter int                ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] ADDR_MIN = '0,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 'h7FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_min_i,
    input  logic              load_max_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        unique case (1'b1)
            load_min_i: addr_d = ADDR_MIN;
            load_max_i: addr_d = ADDR_MAX;
            inc_i:
                addr_d = (addr_q == ADDR_MAX) ? ADDR_MIN
                                              : addr_q + ADDR_W'(1);
            dec_i:
                addr_d = (addr_q == ADDR_MIN) ? ADDR_MAX
                                              : addr_q - ADDR_W'(1);
            default: addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= ADDR_MIN;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/flash_audio_stream_fsm.sv
// Flash-to-audio streamer: fetches words over Avalon-MM, then
// emits one sample slice per sample_tick in forward or reverse order.
module flash_audio_stream_fsm
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W   = 23,
    parameter int                DATA_W   = 32,
    parameter int                SAMPLE_W = 16,
    parameter logic [ADDR_W-1:0] ADDR_MIN = '0,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 'h7FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                play,
    input  logic                dir,
    input  logic                restart,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    input  logic                flash_mem_waitrequest,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic [SAMPLE_W-1:0] audio_data,
    output logic                audio_valid,
    output logic                underrun
);

    localparam int SAMPLES = samples_per_word(DATA_W, SAMPLE_W);
    localparam int IDX_W   = idx_width(SAMPLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);

    if (DATA_W % SAMPLE_W != 0) begin : g_width_chk
        $error("DATA_W must be a multiple of SAMPLE_W");
    end

    state_e              state_q;
    logic                read_q;
    logic                valid_q;
    logic                under_q;
    logic                pend_q;
    logic                wdir_q;
    logic [DATA_W-1:0]   data_q;
    logic [IDX_W-1:0]    idx_q;
    logic [SAMPLE_W-1:0] audio_q;

    logic                tick_go;
    logic                fetching;
    logic                accept;
    logic                rst_go;
    logic                ld_min;
    logic                ld_max;
    logic                step_inc;
    logic                step_dec;
    logic                last;
    logic [SAMPLE_W-1:0] slice;

    always_comb begin
        tick_go  = sample_tick & play;
        fetching = (state_q == ST_REQ) | (state_q == ST_WAIT)
                 | (state_q == ST_ADV);
        accept   = (state_q == ST_REQ) & ~flash_mem_waitrequest;
        // A restart seen in WAIT is deferred until the word lands.
        rst_go   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_PLAY, ST_ADV: rst_go = restart;
            ST_REQ:  rst_go = restart & flash_mem_waitrequest;
            ST_WAIT: rst_go = flash_mem_readdatavalid
                            & (pend_q | restart);
            default: rst_go = 1'b0;
        endcase
        ld_min   = rst_go & dir;
        ld_max   = rst_go & ~dir;
        step_inc = (state_q == ST_ADV) & ~restart & dir;
        step_dec = (state_q == ST_ADV) & ~restart & ~dir;
        last     = wdir_q ? (idx_q == IDX_LAST) : (idx_q == '0);
        slice    = data_q[int'(idx_q) * SAMPLE_W +: SAMPLE_W];
    end

    flash_addr_ctr #(
        .ADDR_W   (ADDR_W),
        .ADDR_MIN (ADDR_MIN),
        .ADDR_MAX (ADDR_MAX)
    ) u_addr (
        .clk        (clk),
        .reset      (reset),
        .load_min_i (ld_min),
        .load_max_i (ld_max),
        .inc_i      (step_inc),
        .dec_i      (step_dec),
        .addr_o     (flash_mem_address)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
            under_q <= 1'b0;
            pend_q  <= 1'b0;
            wdir_q  <= 1'b1;
            data_q  <= '0;
            idx_q   <= '0;
            audio_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (restart) begin
                under_q <= 1'b0;
            end else if (fetching & tick_go) begin
                under_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        state_q <= ST_REQ;
                        read_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (accept) begin
                        state_q <= ST_WAIT;
                        read_q  <= 1'b0;
                        pend_q  <= restart;
                    end
                end
                ST_WAIT: begin
                    if (restart) begin
                        pend_q <= 1'b1;
                    end
                    if (flash_mem_readdatavalid) begin
                        pend_q <= 1'b0;
                        if (pend_q | restart) begin
                            state_q <= ST_REQ;
                            read_q  <= 1'b1;
                        end else begin
                            data_q  <= flash_mem_readdata;
                            wdir_q  <= dir;
                            idx_q   <= dir ? '0 : IDX_LAST;
                            state_q <= ST_PLAY;
                        end
                    end
                end
                ST_PLAY: begin
                    if (restart) begin
                        state_q <= ST_REQ;
                        read_q  <= 1'b1;
                    end else if (tick_go) begin
                        audio_q <= slice;
                        valid_q <= 1'b1;
                        if (last) begin
                            state_q <= ST_ADV;
                        end else if (wdir_q) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end else begin
                            idx_q <= idx_q - IDX_W'(1);
                        end
                    end
                end
                ST_ADV: begin
                    state_q <= ST_REQ;
                    read_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    read_q  <= 1'b0;
                end
            endcase
        end
    end

    assign flash_mem_read = read_q;
    assign audio_data     = audio_q;
    assign audio_valid    = valid_q;
    assign underrun       = under_q;

endmodule
